// File: rtl/inst_fetch_unit.sv
// Instruction fetch stage: PC, single-outstanding imem request channel and a small
// {pc, instr} FIFO feeding decode. Redirects flush the FIFO and squash in-flight fetches.
module inst_fetch_unit #(
    parameter int unsigned     XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0,
    parameter int unsigned     DEPTH    = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic            imem_req_valid_o,
    input  logic            imem_req_ready_i,
    output logic [XLEN-1:0] imem_req_addr_o,
    input  logic            imem_rsp_valid_i,
    input  logic [31:0]     imem_rsp_data_i,
    input  logic            redirect_valid_i,
    input  logic [XLEN-1:0] redirect_pc_i,
    output logic            id_valid_o,
    input  logic            id_ready_i,
    output logic [31:0]     id_instr_o,
    output logic [XLEN-1:0] id_pc_o,
    output logic [6:0]      id_opcode_o
);

    localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CntW = $clog2(DEPTH + 1);

    localparam logic [1:0] ST_REQ  = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_DROP = 2'd2;

    logic [1:0]      state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] req_pc_q, req_pc_d;
    logic            run_q;
    logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CntW-1:0] count_q, count_d;

    logic [XLEN-1:0] pc_mem    [DEPTH];
    logic [31:0]     instr_mem [DEPTH];

    logic req_fire;
    logic push;
    logic pop;
    logic unused_redirect_lsb;

    assign unused_redirect_lsb = ^redirect_pc_i[1:0];

    // run_q keeps the request channel quiet until the first clock after reset release.
    always_comb begin
        imem_req_valid_o = run_q && (state_q == ST_REQ) && (count_q < CntW'(DEPTH));
        imem_req_addr_o  = pc_q;
        req_fire         = imem_req_valid_o && imem_req_ready_i;
        id_valid_o       = (count_q != '0);
        push             = (state_q == ST_WAIT) && imem_rsp_valid_i && !redirect_valid_i;
        pop              = id_valid_o && id_ready_i && !redirect_valid_i;
        id_instr_o       = id_valid_o ? instr_mem[rd_ptr_q] : '0;
        id_pc_o          = id_valid_o ? pc_mem[rd_ptr_q] : '0;
        id_opcode_o      = id_instr_o[6:0];
    end

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        req_pc_d = req_pc_q;
        case (state_q)
            ST_REQ: begin
                if (req_fire) begin
                    req_pc_d = pc_q;
                    pc_d     = pc_q + XLEN'(4);
                    state_d  = redirect_valid_i ? ST_DROP : ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (imem_rsp_valid_i) begin
                    state_d = ST_REQ;
                end else if (redirect_valid_i) begin
                    state_d = ST_DROP;
                end
            end
            ST_DROP: begin
                if (imem_rsp_valid_i) begin
                    state_d = ST_REQ;
                end
            end
            default: state_d = ST_REQ;
        endcase
        if (redirect_valid_i) begin
            pc_d = {redirect_pc_i[XLEN-1:2], 2'b00};
        end
    end

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (redirect_valid_i) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                wr_ptr_d = (wr_ptr_q == PtrW'(DEPTH - 1)) ? '0 : wr_ptr_q + PtrW'(1);
            end
            if (pop) begin
                rd_ptr_d = (rd_ptr_q == PtrW'(DEPTH - 1)) ? '0 : rd_ptr_q + PtrW'(1);
            end
            if (push && !pop) begin
                count_d = count_q + CntW'(1);
            end else if (pop && !push) begin
                count_d = count_q - CntW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_REQ;
            pc_q     <= RESET_PC;
            req_pc_q <= '0;
            run_q    <= 1'b0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            req_pc_q <= req_pc_d;
            run_q    <= 1'b1;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is only read under id_valid, so it needs no reset.
    always_ff @(posedge clk) begin
        if (push) begin
            pc_mem[wr_ptr_q]    <= req_pc_q;
            instr_mem[wr_ptr_q] <= imem_rsp_data_i;
        end
    end

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Directed bench for inst_fetch_unit; a small imem model answers each accepted request
// with data = 0xC0DE0013 + addr, optionally holding the response back.
module tb_inst_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        id_valid;
    logic        id_ready;
    logic [31:0] id_instr;
    logic [31:0] id_pc;
    logic [6:0]  id_opcode;

    logic        hold_rsp;
    logic        pend_q;
    logic [31:0] pend_addr_q;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    inst_fetch_unit #(
        .XLEN    (32),
        .RESET_PC(32'h0),
        .DEPTH   (2)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .imem_req_valid_o(imem_req_valid),
        .imem_req_ready_i(imem_req_ready),
        .imem_req_addr_o (imem_req_addr),
        .imem_rsp_valid_i(imem_rsp_valid),
        .imem_rsp_data_i (imem_rsp_data),
        .redirect_valid_i(redirect_valid),
        .redirect_pc_i   (redirect_pc),
        .id_valid_o      (id_valid),
        .id_ready_i      (id_ready),
        .id_instr_o      (id_instr),
        .id_pc_o         (id_pc),
        .id_opcode_o     (id_opcode)
    );

    // imem model: one response per accepted request, one cycle later unless held.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_q      <= 1'b0;
            pend_addr_q <= '0;
        end else begin
            pend_q <= (pend_q && hold_rsp) || (imem_req_valid && imem_req_ready);
            if (imem_req_valid && imem_req_ready) pend_addr_q <= imem_req_addr;
        end
    end
    assign imem_rsp_valid = pend_q && !hold_rsp;
    assign imem_rsp_data  = 32'hC0DE_0013 + pend_addr_q;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n          = 1'b0;
        imem_req_ready = 1'b0;
        id_ready       = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        hold_rsp       = 1'b0;
        step();
        step();
        chk("rst_req_valid", 32'(imem_req_valid), 32'd0);
        chk("rst_id_valid", 32'(id_valid), 32'd0);
        chk("rst_id_pc", id_pc, 32'h0);
        chk("rst_id_instr", id_instr, 32'h0);
        chk("rst_id_opcode", 32'(id_opcode), 32'h0);
        chk("rst_addr", imem_req_addr, 32'h0);

        // 1: streaming fetch
        rst_n          = 1'b1;
        imem_req_ready = 1'b1;
        id_ready       = 1'b1;
        step();
        chk("t1_req0_valid", 32'(imem_req_valid), 32'd1);
        chk("t1_req0_addr", imem_req_addr, 32'h0);
        step();
        chk("t1_wait_valid", 32'(imem_req_valid), 32'd0);
        chk("t1_wait_idv", 32'(id_valid), 32'd0);
        step();
        chk("t1_idv0", 32'(id_valid), 32'd1);
        chk("t1_idpc0", id_pc, 32'h0);
        chk("t1_instr0", id_instr, 32'hC0DE_0013);
        chk("t1_opc0", 32'(id_opcode), 32'h13);
        chk("t1_req1_addr", imem_req_addr, 32'h4);
        chk("t1_req1_valid", 32'(imem_req_valid), 32'd1);
        step();
        chk("t1_popped", 32'(id_valid), 32'd0);
        step();
        chk("t1_idpc1", id_pc, 32'h4);
        chk("t1_instr1", id_instr, 32'hC0DE_0017);
        chk("t1_req2_addr", imem_req_addr, 32'h8);

        // 2: backpressure fills the FIFO
        id_ready = 1'b0;
        step();
        chk("t2_wait", 32'(imem_req_valid), 32'd0);
        step();
        chk("t2_full_gate", 32'(imem_req_valid), 32'd0);
        chk("t2_head", id_pc, 32'h4);
        step();
        chk("t2_head_stable_pc", id_pc, 32'h4);
        chk("t2_head_stable_instr", id_instr, 32'hC0DE_0017);
        chk("t2_still_gated", 32'(imem_req_valid), 32'd0);
        id_ready = 1'b1;
        step();
        id_ready = 1'b0;
        chk("t2_pop_pc", id_pc, 32'h8);
        chk("t2_pop_instr", id_instr, 32'hC0DE_001B);
        chk("t2_pop_opc", 32'(id_opcode), 32'h1B);
        chk("t2_new_req_valid", 32'(imem_req_valid), 32'd1);
        chk("t2_new_req_addr", imem_req_addr, 32'hC);
        step();
        chk("t2_wait_c", 32'(imem_req_valid), 32'd0);
        step();
        chk("t2_full_again", 32'(imem_req_valid), 32'd0);
        chk("t2_head_8", id_pc, 32'h8);

        // 3: imem stall holds the request
        imem_req_ready = 1'b0;
        id_ready       = 1'b1;
        step();
        chk("t3_head_c", id_pc, 32'hC);
        step();
        chk("t3_drained", 32'(id_valid), 32'd0);
        for (int i = 0; i < 5; i++) begin
            chk("t3_stall_valid", 32'(imem_req_valid), 32'd1);
            chk("t3_stall_addr", imem_req_addr, 32'h10);
            step();
        end
        hold_rsp       = 1'b1;
        imem_req_ready = 1'b1;
        id_ready       = 1'b0;
        step();
        chk("t3_one_accept", 32'(imem_req_valid), 32'd0);

        // 4: redirect while waiting; stale response dropped
        redirect_valid = 1'b1;
        redirect_pc    = 32'h103;
        step();
        redirect_valid = 1'b0;
        chk("t4_drop_valid", 32'(imem_req_valid), 32'd0);
        chk("t4_drop_idv", 32'(id_valid), 32'd0);
        hold_rsp = 1'b0;
        step();
        chk("t4_no_push", 32'(id_valid), 32'd0);
        chk("t4_req_valid", 32'(imem_req_valid), 32'd1);
        chk("t4_req_addr", imem_req_addr, 32'h100);
        step();
        step();
        chk("t4_idv", 32'(id_valid), 32'd1);
        chk("t4_idpc", id_pc, 32'h100);
        chk("t4_instr", id_instr, 32'hC0DE_0113);
        chk("t4_next_addr", imem_req_addr, 32'h104);

        // 5a: redirect in the same cycle as the response
        step();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h200;
        step();
        redirect_valid = 1'b0;
        chk("t5a_flush", 32'(id_valid), 32'd0);
        chk("t5a_req_valid", 32'(imem_req_valid), 32'd1);
        chk("t5a_req_addr", imem_req_addr, 32'h200);
        step();
        step();
        chk("t5a_idpc", id_pc, 32'h200);
        chk("t5a_instr", id_instr, 32'hC0DE_0213);
        step();
        step();
        chk("t5a_full", 32'(imem_req_valid), 32'd0);

        // 5b: redirect in the same cycle as a pop of a full FIFO
        id_ready       = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h300;
        step();
        redirect_valid = 1'b0;
        id_ready       = 1'b0;
        chk("t5b_flush", 32'(id_valid), 32'd0);
        chk("t5b_req_valid", 32'(imem_req_valid), 32'd1);
        chk("t5b_req_addr", imem_req_addr, 32'h300);
        step();
        step();
        chk("t5b_idpc", id_pc, 32'h300);
        chk("t5b_instr", id_instr, 32'hC0DE_0313);

        // 6: reset mid-WAIT, then PC wrap
        step();
        rst_n = 1'b0;
        #1;
        chk("t6_rst_idv", 32'(id_valid), 32'd0);
        chk("t6_rst_req_valid", 32'(imem_req_valid), 32'd0);
        chk("t6_rst_pc", imem_req_addr, 32'h0);
        chk("t6_rst_idpc", id_pc, 32'h0);
        step();
        step();
        rst_n          = 1'b1;
        imem_req_ready = 1'b0;
        step();
        chk("t6_first_valid", 32'(imem_req_valid), 32'd1);
        chk("t6_first_addr", imem_req_addr, 32'h0);
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFFF;
        step();
        redirect_valid = 1'b0;
        chk("t6_wrap_addr", imem_req_addr, 32'hFFFF_FFFC);
        chk("t6_wrap_valid", 32'(imem_req_valid), 32'd1);
        imem_req_ready = 1'b1;
        step();
        step();
        chk("t6_wrap_idpc", id_pc, 32'hFFFF_FFFC);
        chk("t6_wrap_instr", id_instr, 32'hC0DE_000F);
        chk("t6_wrap_next", imem_req_addr, 32'h0);
        chk("t6_wrap_next_valid", 32'(imem_req_valid), 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
